match_stream_checker: RTL

//  Synthesizable scoreboard for keypoint-match records (src x/y/depth, dst x/y/depth).

---
 rtl/match_stream_checker_if.sv | 33 +++
 rtl/match_stream_checker.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/match_stream_checker_if.sv
`default_nettype none
// ============================================================================
// Module      : match_stream_checker_if
// Description : Golden and DUT record streams feeding the match checker.
//               Each stream uses a valid/ready handshake, and a last flag that
//               counts only when the handshake completes.
//   master : drives g_valid/g_data/g_last and d_valid/d_data/d_last
//   slave  : drives g_ready and d_ready (the checker side)
// Revision    : 1.0 - initial release
// ============================================================================
interface match_stream_checker_if #(
    parameter int REC_W = 60
);
    logic             g_valid;
    logic             g_ready;
    logic [REC_W-1:0] g_data;
    logic             g_last;
    logic             d_valid;
    logic             d_ready;
    logic [REC_W-1:0] d_data;
    logic             d_last;

    modport master (
        output g_valid, g_data, g_last, d_valid, d_data, d_last,
        input  g_ready, d_ready
    );

    modport slave (
        input  g_valid, g_data, g_last, d_valid, d_data, d_last,
        output g_ready, d_ready
    );
endinterface
`default_nettype wire

// File: rtl/match_stream_checker.sv
`default_nettype none
// ============================================================================
// Module      : match_stream_checker
// Description : Scoreboard for keypoint-match records {sx,sy,sd,dx,dy,dd}.
//               Golden records are held in a circular lookahead window. Each
//               DUT record is searched for in that window. The checker reports
//               PASS when the record is found, LACK for each golden record
//               skipped over, and EXTRA when the DUT record is not found.
//               Event counters saturate at their maximum value.
// Ports       : clk, rst_n (asynchronous, active low)
//               bus       - golden/DUT stream handshakes (slave modport)
//               ev_valid/ev_type/ev_data - one-cycle event
//                           (0=PASS 1=LACK 2=EXTRA)
//               pass_cnt/lack_cnt/extra_cnt - saturating event totals
//               done      - sticky: both streams have ended and the window
//                           is empty
// Config      : define CHK_DEPTH_TOL_EN to make the depth fields match when
//               |g-d| <= DEPTH_TOL. The coordinate fields always need an
//               exact match.
// Revision    : 1.0 - initial release
// ============================================================================
module match_stream_checker #(
    parameter  int COORD_W   = 10,
    parameter  int DEPTH_W   = 10,
    parameter  int WIN       = 8,
    parameter  int CNT_W     = 16,
    parameter  int DEPTH_TOL = 0,
    localparam int c_REC_W   = 4*COORD_W + 2*DEPTH_W
) (
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    match_stream_checker_if.slave     bus,
    output logic                      ev_valid,
    output logic [1:0]                ev_type,
    output logic [c_REC_W-1:0]        ev_data,
    output logic [CNT_W-1:0]          pass_cnt,
    output logic [CNT_W-1:0]          lack_cnt,
    output logic [CNT_W-1:0]          extra_cnt,
    output logic                      done
);
    localparam int c_PTR_W = $clog2(WIN);
    localparam logic [c_PTR_W:0] c_WIN_F = (c_PTR_W+1)'(WIN);
    localparam logic [c_PTR_W:0] c_IDX1  = (c_PTR_W+1)'(1);
    localparam logic [1:0] c_EV_PASS  = 2'd0;
    localparam logic [1:0] c_EV_LACK  = 2'd1;
    localparam logic [1:0] c_EV_EXTRA = 2'd2;
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    // Field LSB positions inside a packed record (sx sits in the MSBs).
    localparam int c_DY_LSB = DEPTH_W;
    localparam int c_DX_LSB = DEPTH_W + COORD_W;
    localparam int c_SD_LSB = DEPTH_W + 2*COORD_W;
    localparam int c_SY_LSB = 2*DEPTH_W + 2*COORD_W;
    localparam int c_SX_LSB = 2*DEPTH_W + 3*COORD_W;

`ifdef CHK_DEPTH_TOL_EN
    localparam logic [DEPTH_W-1:0] c_TOL = DEPTH_W'(DEPTH_TOL);
`else
    // A zero tolerance reduces the depth compare to exact equality.
    localparam logic [DEPTH_W-1:0] c_TOL = DEPTH_W'(DEPTH_TOL * 0);
`endif

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CMP    = 3'd1,
        S_SEARCH = 3'd2,
        S_DRAIN  = 3'd3,
        S_FLUSH  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [c_REC_W-1:0]    r_mem [WIN];
    logic [c_PTR_W-1:0]    r_head;
    logic [c_PTR_W:0]      r_fill;
    logic                  r_g_end, r_d_end;
    logic [c_REC_W-1:0]    r_dreg;
    logic [c_PTR_W:0]      r_idx, w_idx_nxt;
    logic [c_PTR_W:0]      r_k, w_k_nxt;
    logic                  r_ev_valid;
    logic [1:0]            r_ev_type;
    logic [c_REC_W-1:0]    r_ev_data;
    logic [CNT_W-1:0]      r_pass, r_lack, r_extra;

    logic                  w_g_ready, w_d_ready, w_push, w_d_hs, w_pop;
    logic                  w_ev_fire;
    logic [1:0]            w_ev_type;
    logic [c_REC_W-1:0]    w_ev_data;
    logic [c_PTR_W-1:0]    w_tail, w_sptr;
    logic [c_REC_W-1:0]    w_head_rec, w_srch_rec;

    function automatic logic f_dep_ok(input logic [DEPTH_W-1:0] a, input logic [DEPTH_W-1:0] b);
        logic [DEPTH_W-1:0] diff;
        diff = (a > b) ? (a - b) : (b - a);
        return diff <= c_TOL;
    endfunction

    function automatic logic f_match(input logic [c_REC_W-1:0] g, input logic [c_REC_W-1:0] d);
        return (g[c_SX_LSB +: COORD_W] == d[c_SX_LSB +: COORD_W]) &&
               (g[c_SY_LSB +: COORD_W] == d[c_SY_LSB +: COORD_W]) &&
               (g[c_DX_LSB +: COORD_W] == d[c_DX_LSB +: COORD_W]) &&
               (g[c_DY_LSB +: COORD_W] == d[c_DY_LSB +: COORD_W]) &&
               f_dep_ok(g[c_SD_LSB +: DEPTH_W], d[c_SD_LSB +: DEPTH_W]) &&
               f_dep_ok(g[DEPTH_W-1:0], d[DEPTH_W-1:0]);
    endfunction

    assign w_g_ready   = (r_fill != c_WIN_F) && !r_g_end;
    assign w_d_ready   = (r_state == S_IDLE) && !r_d_end;
    assign bus.g_ready = w_g_ready;
    assign bus.d_ready = w_d_ready;
    assign w_push      = bus.g_valid && w_g_ready;
    assign w_d_hs      = bus.d_valid && w_d_ready;
    assign w_tail      = r_head + r_fill[c_PTR_W-1:0];
    assign w_sptr      = r_head + r_idx[c_PTR_W-1:0];
    assign w_head_rec  = r_mem[r_head];
    assign w_srch_rec  = r_mem[w_sptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_ev_fire   = 1'b0;
        w_ev_type   = c_EV_PASS;
        w_ev_data   = w_head_rec;
        w_idx_nxt   = r_idx;
        w_k_nxt     = r_k;
        case (r_state)
            S_IDLE: begin
                if (w_d_hs)       w_state_nxt = S_CMP;
                else if (r_d_end) w_state_nxt = S_FLUSH;
            end
            S_CMP: begin
                if (r_fill == '0) begin
                    // Window empty: the DUT record is extra only once golden has ended.
                    if (r_g_end) begin
                        w_ev_fire   = 1'b1;
                        w_ev_type   = c_EV_EXTRA;
                        w_ev_data   = r_dreg;
                        w_state_nxt = S_IDLE;
                    end
                end else if (f_match(w_head_rec, r_dreg)) begin
                    w_ev_fire   = 1'b1;
                    w_pop       = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_idx_nxt   = c_IDX1;
                    w_state_nxt = S_SEARCH;
                end
            end
            S_SEARCH: begin
                if (r_idx == r_fill) begin
                    // Searched past the last entry. Declare EXTRA only when no
                    // more golden can arrive. Otherwise hold idx for the next push.
                    if ((r_fill == c_WIN_F) || r_g_end) begin
                        w_ev_fire   = 1'b1;
                        w_ev_type   = c_EV_EXTRA;
                        w_ev_data   = r_dreg;
                        w_state_nxt = S_IDLE;
                    end
                end else if (f_match(w_srch_rec, r_dreg)) begin
                    w_k_nxt     = r_idx;
                    w_state_nxt = S_DRAIN;
                end else begin
                    w_idx_nxt = r_idx + 1'b1;
                end
            end
            S_DRAIN: begin
                // Entries ahead of the match are lacking. The matched entry is last.
                w_ev_fire = 1'b1;
                w_pop     = 1'b1;
                if (r_k != '0) begin
                    w_ev_type = c_EV_LACK;
                    w_k_nxt   = r_k - 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_FLUSH: begin
                if (r_fill != '0) begin
                    w_ev_fire = 1'b1;
                    w_ev_type = c_EV_LACK;
                    w_pop     = 1'b1;
                end else if (r_g_end) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  ;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Window storage carries no reset; validity is tracked by head/fill.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[w_tail] <= bus.g_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head     <= '0;
            r_fill     <= '0;
            r_g_end    <= 1'b0;
            r_d_end    <= 1'b0;
            r_dreg     <= '0;
            r_idx      <= '0;
            r_k        <= '0;
            r_ev_valid <= 1'b0;
            r_ev_type  <= '0;
            r_ev_data  <= '0;
            r_pass     <= '0;
            r_lack     <= '0;
            r_extra    <= '0;
        end else begin
            if (w_pop) r_head <= r_head + 1'b1;
            if (w_push && !w_pop)      r_fill <= r_fill + 1'b1;
            else if (!w_push && w_pop) r_fill <= r_fill - 1'b1;
            if (w_push && bus.g_last) r_g_end <= 1'b1;
            if (w_d_hs) begin
                r_dreg <= bus.d_data;
                if (bus.d_last) r_d_end <= 1'b1;
            end
            r_idx      <= w_idx_nxt;
            r_k        <= w_k_nxt;
            r_ev_valid <= w_ev_fire;
            if (w_ev_fire) begin
                r_ev_type <= w_ev_type;
                r_ev_data <= w_ev_data;
                case (w_ev_type)
                    c_EV_PASS:  if (r_pass  != c_CNT_MAX) r_pass  <= r_pass  + 1'b1;
                    c_EV_LACK:  if (r_lack  != c_CNT_MAX) r_lack  <= r_lack  + 1'b1;
                    default:    if (r_extra != c_CNT_MAX) r_extra <= r_extra + 1'b1;
                endcase
            end
        end
    end

    assign ev_valid  = r_ev_valid;
    assign ev_type   = r_ev_type;
    assign ev_data   = r_ev_data;
    assign pass_cnt  = r_pass;
    assign lack_cnt  = r_lack;
    assign extra_cnt = r_extra;
    assign done      = (r_state == S_DONE);

endmodule
`default_nettype wire
